// File: rtl/wb_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
package wb_pkg;

   localparam int unsigned WB_DEPTH  = 4;
   localparam int unsigned WB_ADDR_W = 5;
   localparam int unsigned WB_DATA_W = 32;

   localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of write-back entries: two ordered push ports (a before b),
// one pop port, with every slot and its valid bit exposed for pending-write lookup.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH = WB_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_a,
   input  wb_entry_t              entry_a,
   input  logic                   push_b,
   input  wb_entry_t              entry_b,
   input  logic                   pop,
   output wb_entry_t              head,
   output wb_entry_t [DEPTH-1:0]  entries,
   output logic      [DEPTH-1:0]  valid,
   output logic      [PTR_W-1:0]  head_idx,
   output logic      [CNT_W-1:0]  count
);

   function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
      return a - b;
   endfunction

   wb_entry_t [DEPTH-1:0] mem;
   logic      [PTR_W-1:0] rd_ptr;
   logic      [PTR_W-1:0] wr_ptr;
   logic      [PTR_W-1:0] b_idx;

   // Port b lands behind port a when both push in the same cycle.
   assign b_idx = push_a ? wr_ptr + PTR_W'(1) : wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(pop);
         wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
         count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push_a) mem[wr_ptr] <= entry_a;
      if (push_b) mem[b_idx]  <= entry_b;
   end

   // A slot is live when its age behind the head is below the occupancy.
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = CNT_W'(ptr_sub(PTR_W'(i), rd_ptr)) < count;
      end
   end

   assign head     = mem[rd_ptr];
   assign entries  = mem;
   assign head_idx = rd_ptr;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load write-backs into an in-order queue draining to the register-file
// write port. Define WB_BYPASS_EN to build the newest-pending-value lookup ports.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH  = WB_DEPTH,
   parameter  int unsigned ADDR_W = WB_ADDR_W,
   parameter  int unsigned DATA_W = WB_DATA_W,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              MemValid,
   input  logic [ADDR_W-1:0] MemReg,
   input  logic [DATA_W-1:0] MemData,
   output logic              MemReady,
   input  logic              AluValid,
   input  logic [ADDR_W-1:0] AluReg,
   input  logic [DATA_W-1:0] AluData,
   output logic              AluReady,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] LookupReg1,
   input  logic [ADDR_W-1:0] LookupReg2,
   output logic              LookupHit1,
   output logic              LookupHit2,
   output logic [DATA_W-1:0] LookupData1,
   output logic [DATA_W-1:0] LookupData2,
   output logic [CNT_W-1:0]  Count
);

   logic                  mem_live;
   logic                  mem_push;
   logic                  alu_push;
   logic                  pop;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic      [DEPTH-1:0] valid;
   logic      [PTR_W-1:0] head_idx;

   // Readiness is judged on the registered occupancy only; the same-cycle pop earns no credit.
   assign mem_live = MemValid && (MemReg != REG_ZERO);
   assign MemReady = Count < CNT_W'(DEPTH);
   assign AluReady = (Count + CNT_W'(mem_live)) < CNT_W'(DEPTH);
   assign mem_push = mem_live && MemReady;
   assign alu_push = AluValid && AluReady && (AluReg != REG_ZERO);
   assign pop      = Count != '0;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .push_a   (mem_push),
      .entry_a  (wb_entry_t'{rd: MemReg, data: MemData}),
      .push_b   (alu_push),
      .entry_b  (wb_entry_t'{rd: AluReg, data: AluData}),
      .pop      (pop),
      .head     (head),
      .entries  (entries),
      .valid    (valid),
      .head_idx (head_idx),
      .count    (Count)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
      end else begin
         RegWrite <= pop;
         if (pop) begin
            WriteRegister <= head.rd;
            WriteData     <= head.data;
         end
      end
   end

`ifdef WB_BYPASS_EN
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] a, input int k);
      return a + PTR_W'(k);
   endfunction

   // Scan oldest to youngest so later matches override: output register first, then queue.
   always_comb begin
      LookupHit1  = 1'b0;
      LookupData1 = '0;
      LookupHit2  = 1'b0;
      LookupData2 = '0;
      if (RegWrite && (WriteRegister == LookupReg1)) begin
         LookupHit1  = 1'b1;
         LookupData1 = WriteData;
      end
      if (RegWrite && (WriteRegister == LookupReg2)) begin
         LookupHit2  = 1'b1;
         LookupData2 = WriteData;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (valid[ptr_add(head_idx, k)] && (entries[ptr_add(head_idx, k)].rd == LookupReg1)) begin
            LookupHit1  = 1'b1;
            LookupData1 = entries[ptr_add(head_idx, k)].data;
         end
         if (valid[ptr_add(head_idx, k)] && (entries[ptr_add(head_idx, k)].rd == LookupReg2)) begin
            LookupHit2  = 1'b1;
            LookupData2 = entries[ptr_add(head_idx, k)].data;
         end
      end
      if (LookupReg1 == REG_ZERO) begin
         LookupHit1  = 1'b0;
         LookupData1 = '0;
      end
      if (LookupReg2 == REG_ZERO) begin
         LookupHit2  = 1'b0;
         LookupData2 = '0;
      end
   end
`else
   logic unused_lookup;
   assign unused_lookup = ^{LookupReg1, LookupReg2, entries, valid, head_idx};
   assign LookupHit1    = 1'b0;
   assign LookupHit2    = 1'b0;
   assign LookupData1   = '0;
   assign LookupData2   = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected writes queued on accept, checked on RegWrite.
module tb_writeback_arbiter;
   import wb_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        MemValid, AluValid;
   logic [4:0]  MemReg, AluReg, LookupReg1, LookupReg2;
   logic [31:0] MemData, AluData;
   logic        MemReady, AluReady, RegWrite, LookupHit1, LookupHit2;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData, LookupData1, LookupData2;
   logic [2:0]  Count;

   writeback_arbiter dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
      .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .LookupReg1(LookupReg1), .LookupReg2(LookupReg2),
      .LookupHit1(LookupHit1), .LookupHit2(LookupHit2),
      .LookupData1(LookupData1), .LookupData2(LookupData2),
      .Count(Count)
   );

   always #5 Clk = ~Clk;

   int        vectors    = 0;
   int        miscompares = 0;
   wb_entry_t sb[$];
   int        cnt       = 0;
   logic      out_valid = 1'b0;
   wb_entry_t last_out  = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void exp_lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
`ifdef WB_BYPASS_EN
      if (r != 5'd0) begin
         if (out_valid && last_out.rd == r) begin
            hit = 1'b1;
            d   = last_out.data;
         end
         foreach (sb[i]) begin
            if (sb[i].rd == r) begin
               hit = 1'b1;
               d   = sb[i].data;
            end
         end
      end
`endif
   endfunction

   // One clock: drive at negedge, check combinational outputs, advance model at posedge,
   // check registered outputs at the following negedge.
   task automatic cycle(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic [4:0] l1, input logic [4:0] l2);
      logic        em, ea, mp, ap, exp_rw, h;
      logic [31:0] d;
      MemValid = mv; MemReg = mr; MemData = md;
      AluValid = av; AluReg = ar; AluData = ad;
      LookupReg1 = l1; LookupReg2 = l2;
      #1;
      em = (cnt < DEPTH);
      ea = ((cnt + ((mv && mr != 5'd0) ? 1 : 0)) < DEPTH);
      check("mem_ready", MemReady, em);
      check("alu_ready", AluReady, ea);
      exp_lookup(l1, h, d);
      check("hit1", LookupHit1, h);
      check("data1", LookupData1, d);
      exp_lookup(l2, h, d);
      check("hit2", LookupHit2, h);
      check("data2", LookupData2, d);
      mp = mv && em && (mr != 5'd0);
      ap = av && ea && (ar != 5'd0);
      @(posedge Clk);
      exp_rw = (cnt > 0);
      cnt = cnt + (mp ? 1 : 0) + (ap ? 1 : 0) - (exp_rw ? 1 : 0);
      if (mp) sb.push_back('{rd: mr, data: md});
      if (ap) sb.push_back('{rd: ar, data: ad});
      @(negedge Clk);
      check("reg_write", RegWrite, exp_rw);
      out_valid = exp_rw;
      if (RegWrite) begin
         check("sb_nonempty", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            last_out = sb.pop_front();
            check("write_reg", WriteRegister, last_out.rd);
            check("write_data", WriteData, last_out.data);
         end
      end
      check("count", Count, cnt);
   endtask

   task automatic idle(input logic [4:0] l1, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, l1, 5'd0);
   endtask

   initial begin
      Rst_n = 1'b0;
      MemValid = 1'b0; MemReg = '0; MemData = '0;
      AluValid = 1'b0; AluReg = '0; AluData = '0;
      LookupReg1 = '0; LookupReg2 = '0;
      #3;
      check("rst_regwrite", RegWrite, 1'b0);
      check("rst_wreg", WriteRegister, 5'd0);
      check("rst_wdata", WriteData, 32'd0);
      check("rst_count", Count, 3'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(5'd5, 1);

      // single ALU write, one-cycle latency to the write port
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      idle(5'd5, 3);

      // dual push to the same register, Mem ordered first
      cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
      idle(5'd3, 4);

      // fill to Count=3, then probe the boundary ready cases
      cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
      cycle(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, 5'd4, 5'd6);
      cycle(1'b1, 5'd7, 32'hA7, 1'b1, 5'd8, 32'hA8, 5'd7, 5'd8);
      cycle(1'b0, 5'd0, 32'd0,  1'b1, 5'd9, 32'hA9, 5'd9, 5'd7);
      cycle(1'b1, 5'd0, 32'hB0, 1'b1, 5'd10, 32'hAA, 5'd10, 5'd0);

      // ALU to r0 at Count=3: accepted, never enqueued, never hits
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCC, 5'd0, 5'd10);
      idle(5'd0, 5);

      // asynchronous reset mid-drain with Count=3
      cycle(1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hC2, 5'd12, 5'd13);
      cycle(1'b1, 5'd14, 32'hC3, 1'b1, 5'd15, 32'hC4, 5'd14, 5'd15);
      MemValid = 1'b0; AluValid = 1'b0;
      #2;
      Rst_n = 1'b0;
      #1;
      check("mid_rst_regwrite", RegWrite, 1'b0);
      check("mid_rst_count", Count, 3'd0);
      sb.delete();
      cnt = 0;
      out_valid = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(5'd14, 4);

      // random mixed traffic over a small register range
      for (int i = 0; i < 120; i++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(5'd1, 6);
      check("final_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
